seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_alu_muldiv.sv | 87 ++++++++
 rtl/seq_alu.sv | 123 ++++++++++++
 tb/tb_seq_alu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode values carried in control[3:0]
//   - bit positions inside the 3-bit flags output
//   - handshake state machine encoding
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOTA = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative engine for MUL (shift-add), DIVU and REMU
// (restoring, MSB first). One iteration per cycle while step is high.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load operands and mode, clear the iteration counter
//   step         : perform one iteration this cycle
//   is_mul       : 1 = multiply, 0 = divide
//   want_rem     : divide mode returns remainder instead of quotient
//   a, b         : operands (dividend/divisor or multiplicand/multiplier)
//   last         : current iteration is the final one
//   result       : value the operation produces once the current iteration
//                  completes; valid as the final answer when last is high
import alu_pkg::*;

module seq_alu_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_mul,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    logic [CW-1:0]    count;
    logic             mode_mul;
    logic             mode_rem;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    // opx: shifting multiplicand (MUL) or dividend shifting into quotient (DIV)
    // opy: shifting multiplier (MUL) or fixed divisor (DIV)
    logic [WIDTH-1:0] acc, opx, opy;
    logic [WIDTH-1:0] acc_next, opx_next, opy_next;
    logic [WIDTH:0]   r_shift, diff;
    logic             fits;

    // One iteration of the selected algorithm. The remainder path works at
    // WIDTH+1 bits so the trial subtraction's sign bit is exact. A zero
    // divisor always "fits", giving an all-ones quotient and remainder = A.
    always_comb begin
        r_shift  = {acc, opx[WIDTH-1]};
        diff     = r_shift - {1'b0, opy};
        fits     = ~diff[WIDTH];
        acc_next = acc;
        opx_next = opx;
        opy_next = opy;
        if (mode_mul) begin
            acc_next = acc + (opy[0] ? opx : '0);
            opx_next = opx << 1;
            opy_next = opy >> 1;
        end else begin
            acc_next = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
            opx_next = {opx[WIDTH-2:0], fits};
        end
    end

    assign result = (mode_mul || mode_rem) ? acc_next : opx_next;
    assign last   = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            mode_mul <= 1'b0;
            mode_rem <= 1'b0;
            acc      <= '0;
            opx      <= '0;
            opy      <= '0;
        end else if (start) begin
            count    <= '0;
            mode_mul <= is_mul;
            mode_rem <= want_rem;
            acc      <= '0;
            opx      <= a;
            opy      <= b;
        end else if (step) begin
            count    <= count + 1'b1;
            acc      <= acc_next;
            opx      <= opx_next;
            opy      <= opy_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on input and output.
// Single-cycle ops finish one cycle after accept; MUL/DIVU/REMU use the
// iterative engine and finish WIDTH+1 cycles after accept.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake
//   input1, input2      : operands A and B
//   shamt               : immediate shift amount
//   control             : [4] shift amount from input2 (1) or shamt (0), [3:0] opcode
//   out_valid/out_ready : result handshake
//   out, flags          : result and {carry/borrow, negative, zero}
import alu_pkg::*;

module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shamt,
    input  logic [4:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags
);

    state_t           state, state_next;
    logic             accept, is_multi, md_last;
    logic [3:0]       op;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res, md_result;
    logic             alu_carry;
    logic [WIDTH:0]   add_wide;

    function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] r, input logic c);
        logic [2:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        return f;
    endfunction

    assign op        = control[3:0];
    assign sh        = control[4] ? input2[SHW-1:0] : shamt;
    assign is_multi  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign add_wide  = {1'b0, input1} + {1'b0, input2};

    // Single-cycle datapath, evaluated on the live inputs and only
    // registered on an accept. Opcodes 12-15 fall through to zero.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = add_wide[WIDTH-1:0]; alu_carry = add_wide[WIDTH]; end
            OP_SUB:  begin alu_res = input1 - input2; alu_carry = (input1 < input2); end
            OP_AND:  alu_res = input1 & input2;
            OP_OR:   alu_res = input1 | input2;
            OP_XOR:  alu_res = input1 ^ input2;
            OP_NOTA: alu_res = ~input1;
            OP_SLL:  alu_res = input1 << sh;
            OP_SRL:  alu_res = input1 >> sh;
            OP_SRA:  alu_res = WIDTH'($signed(input1) >>> sh);
            default: ;
        endcase
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_multi),
        .step     (state == ST_BUSY),
        .is_mul   (op == OP_MUL),
        .want_rem (op == OP_REMU),
        .a        (input1),
        .b        (input2),
        .last     (md_last),
        .result   (md_result)
    );

    // Next state. An accept in DONE (possible only with out_ready) starts
    // the new operation without passing through IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = is_multi ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_last) state_next = ST_DONE;
            ST_DONE: begin
                if (accept)         state_next = is_multi ? ST_BUSY : ST_DONE;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // out/flags are only written on the transition into DONE, so they stay
    // stable under backpressure and while a multi-cycle op is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            flags <= '0;
        end else if (accept && !is_multi) begin
            out   <= alu_res;
            flags <= make_flags(alu_res, alu_carry);
        end else if ((state == ST_BUSY) && md_last) begin
            out   <= md_result;
            flags <= make_flags(md_result, 1'b0);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed literal checks plus randomized traffic for seq_alu
// (WIDTH=32), compared every cycle against a transaction-level model.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  input1 = '0;
    logic [W-1:0]  input2 = '0;
    logic [4:0]    shamt = '0;
    logic [4:0]    control = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;
    logic [2:0]    flags;

    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .shamt     (shamt),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference result: {flags, out} straight from the arithmetic definitions.
    function automatic logic [34:0] ref_op(input logic [4:0] ctrl, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] imm);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   s;
        s = ctrl[4] ? b[4:0] : imm;
        r = '0;
        c = 1'b0;
        case (ctrl[3:0])
            4'd0:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << s;
            4'd7:  r = a >> s;
            4'd8:  r = W'($signed(a) >>> s);
            4'd9:  r = W'(a * b);
            4'd10: r = (b == 0) ? '1 : a / b;
            4'd11: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return {c, r[W-1], (r == '0), r};
    endfunction

    // Transaction-level model: a result becomes visible 1 cycle after accept
    // (WIDTH+1 for MUL/DIVU/REMU), is held until out_ready, and the model is
    // ready whenever nothing is in flight and any visible result is leaving.
    logic        m_valid = 1'b0;
    logic [W-1:0] m_out = '0;
    logic [2:0]  m_flags = '0;
    int          m_wait = 0;
    logic [34:0] m_pend = '0;
    logic [34:0] m_res;
    logic        m_ready;

    always_comb m_ready = (m_wait == 0) && (!m_valid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_out   = '0;
            m_flags = '0;
            m_wait  = 0;
        end else if (m_wait != 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                {m_flags, m_out} = m_pend;
            end
        end else if (in_valid && m_ready) begin
            m_res = ref_op(control, input1, input2, shamt);
            if (control[3:0] >= 4'd9 && control[3:0] <= 4'd11) begin
                m_wait  = W;
                m_valid = 1'b0;
                m_pend  = m_res;
            end else begin
                m_valid = 1'b1;
                {m_flags, m_out} = m_res;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        checks++;
        if (in_ready !== m_ready) begin
            failures++;
            $display("[TB] FAIL in_ready actual=%b expected=%b t=%0t", in_ready, m_ready, $time);
        end
        checks++;
        if (out_valid !== m_valid) begin
            failures++;
            $display("[TB] FAIL out_valid actual=%b expected=%b t=%0t", out_valid, m_valid, $time);
        end
        checks++;
        if (out !== m_out) begin
            failures++;
            $display("[TB] FAIL out actual=%h expected=%h t=%0t", out, m_out, $time);
        end
        checks++;
        if (flags !== m_flags) begin
            failures++;
            $display("[TB] FAIL flags actual=%b expected=%b t=%0t", flags, m_flags, $time);
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one request and hold it until the DUT takes it (bounded).
    task automatic applyStimulus(input logic [4:0] ctrl, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] imm);
        logic rdy;
        int   n;
        control  = ctrl;
        input1   = a;
        input2   = b;
        shamt    = imm;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 100);
        #1 in_valid = 1'b0;
        if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Count negedges from accept until out_valid; also count cycles in which
    // in_ready was high before the result appeared.
    task automatic waitResult(output int lat, output int ready_seen);
        lat = 0;
        ready_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) ready_seen++;
        end while (!out_valid && lat < 100);
        if (!out_valid) checkOutput("result_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 20));
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    int lat, rs, stale;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out", out, 32'd0);
        checkOutput("reset_flags", {29'd0, flags}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(5'b00000, 32'hFFFF_FFFF, 32'd1, 5'd0);
        waitResult(lat, rs);
        checkOutput("add_latency", lat, 32'd1);
        checkOutput("add_out", out, 32'd0);
        checkOutput("add_flags", {29'd0, flags}, 32'b101);

        applyStimulus(5'b11000, 32'h8000_0000, 32'd31, 5'd0);
        waitResult(lat, rs);
        checkOutput("sra_out", out, 32'hFFFF_FFFF);
        checkOutput("sra_flags", {29'd0, flags}, 32'b010);

        applyStimulus(5'b00111, 32'h0000_0100, 32'd0, 5'd4);
        waitResult(lat, rs);
        checkOutput("srl_out", out, 32'h10);

        applyStimulus(5'b01001, 32'd12345, -32'sd3, 5'd0);
        waitResult(lat, rs);
        checkOutput("mul_latency", lat, 32'd33);
        checkOutput("mul_ready_busy", rs, 32'd0);
        checkOutput("mul_out", out, 32'hFFFF_6F55);
        checkOutput("mul_flags", {29'd0, flags}, 32'b010);

        applyStimulus(5'b01010, 32'd100, 32'd7, 5'd0);
        waitResult(lat, rs);
        checkOutput("divu_out", out, 32'd14);
        applyStimulus(5'b01011, 32'd100, 32'd7, 5'd0);
        waitResult(lat, rs);
        checkOutput("remu_out", out, 32'd2);
        applyStimulus(5'b01010, 32'd100, 32'd0, 5'd0);
        waitResult(lat, rs);
        checkOutput("divu0_latency", lat, 32'd33);
        checkOutput("divu0_out", out, 32'hFFFF_FFFF);
        applyStimulus(5'b01011, 32'd100, 32'd0, 5'd0);
        waitResult(lat, rs);
        checkOutput("remu0_out", out, 32'd100);

        applyStimulus(5'b01100, 32'd55, 32'd66, 5'd0);
        waitResult(lat, rs);
        checkOutput("op12_out", out, 32'd0);
        checkOutput("op12_flags", {29'd0, flags}, 32'b001);

        // Backpressure then back-to-back accept in DONE.
        @(posedge clk); #1 out_ready = 1'b0;
        applyStimulus(5'b00000, 32'd5, 32'd6, 5'd0);
        waitResult(lat, rs);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out", out, 32'd11);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        #1;
        out_ready = 1'b1;
        control   = 5'b00100;
        input1    = 32'h0000_F0F0;
        input2    = 32'h0000_0FF0;
        in_valid  = 1'b1;
        @(negedge clk);
        #1 in_valid = 1'b0;
        checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("b2b_out", out, 32'h0000_FF00);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        applyStimulus(5'b01001, 32'd7, 32'd9, 5'd0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rst_no_stale", stale, 32'd0);

        // Randomized traffic; the per-cycle compare process does the checking.
        repeat (4000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            control   = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            input1    = rnd_operand();
            input2    = rnd_operand();
            shamt     = 5'($urandom);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (50) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
